// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequences multi-cycle FPU ops from the E stage, stalling the pipe until the result is captured
module fpu_issue_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 12,
  parameter int LAT_CVT  = 2,
  parameter int LAT_MISC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_e,
  input  logic [4:0]  funct5_e,
  input  logic [2:0]  rm_e,
  input  logic [31:0] rs1_e,
  input  logic [31:0] rs2_e,
  input  logic        flush_e,
  input  logic        hold_m,
  input  logic [31:0] fpu_result,
  output logic [31:0] fpu_rd1,
  output logic [31:0] fpu_rd2,
  output logic [2:0]  fpu_rm,
  output logic [4:0]  fpu_funct5,
  output logic        fpu_stall,
  output logic        result_valid,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] cnt, lat;
  logic go;
  always_comb begin
    lat = (funct5_e == 5'b00000 || funct5_e == 5'b00001) ? 5'(LAT_ADD)
        : funct5_e == 5'b00010 ? 5'(LAT_MUL)
        : funct5_e == 5'b00011 ? 5'(LAT_DIV)
        : funct5_e == 5'b01011 ? 5'(LAT_SQRT)
        : (funct5_e == 5'b11000 || funct5_e == 5'b11010) ? 5'(LAT_CVT)
        : 5'(LAT_MISC);
    go = !rst && state == IDLE && issue_e && !flush_e;
    state_nx = state == IDLE ? (go ? BUSY : IDLE)
             : flush_e ? IDLE
             : state == BUSY ? (cnt == 5'd0 ? DONE : BUSY)
             : hold_m ? DONE : IDLE;
    fpu_stall = go || (!rst && state == BUSY && !flush_e);
    result_valid = !rst && state == DONE && !flush_e;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 5'd0;
      fpu_rd1 <= 32'd0;
      fpu_rd2 <= 32'd0;
      fpu_rm <= 3'd0;
      fpu_funct5 <= 5'd0;
      result <= 32'd0;
    end else begin
      state <= state_nx;
      if (go) begin
        fpu_rd1 <= rs1_e;
        fpu_rd2 <= rs2_e;
        fpu_rm <= rm_e;
        fpu_funct5 <= funct5_e;
        cnt <= lat - 5'd1;
      end else if (state == BUSY && !flush_e) begin
        if (cnt == 5'd0) result <= fpu_result;
        else cnt <= cnt - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of issue, latency, flush, hold and reset behaviour
module tb_fpu_issue_ctrl;
  logic clk = 1'b0, rst, issue_e, flush_e, hold_m;
  logic [4:0] funct5_e;
  logic [2:0] rm_e;
  logic [31:0] rs1_e, rs2_e, fpu_result;
  logic [31:0] fpu_rd1, fpu_rd2, result;
  logic [2:0] fpu_rm;
  logic [4:0] fpu_funct5;
  logic fpu_stall, result_valid;
  int total = 0, fails = 0;
  fpu_issue_ctrl dut (
    .clk(clk), .rst(rst), .issue_e(issue_e), .funct5_e(funct5_e), .rm_e(rm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .flush_e(flush_e), .hold_m(hold_m),
    .fpu_result(fpu_result), .fpu_rd1(fpu_rd1), .fpu_rd2(fpu_rd2), .fpu_rm(fpu_rm),
    .fpu_funct5(fpu_funct5), .fpu_stall(fpu_stall), .result_valid(result_valid),
    .result(result)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [4:0] f5, input logic [2:0] rm,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input int lat, input bit keep);
    issue_e = 1'b1;
    funct5_e = f5;
    rm_e = rm;
    rs1_e = a;
    rs2_e = b;
    fpu_result = 32'hBAD0BAD0;
    #1;
    chk({tag, "_issue_stall"}, 32'(fpu_stall), 32'd1);
    chk({tag, "_issue_rv"}, 32'(result_valid), 32'd0);
    cyc;
    if (!keep) begin
      issue_e = 1'b0;
      funct5_e = 5'h1f;
      rm_e = ~rm;
      rs1_e = ~a;
      rs2_e = ~b;
    end
    for (int i = 0; i < lat; i++) begin
      fpu_result = (i == lat - 1) ? res : 32'hDEAD0000 + 32'(i);
      #1;
      chk({tag, "_busy_stall"}, 32'(fpu_stall), 32'd1);
      chk({tag, "_busy_rv"}, 32'(result_valid), 32'd0);
      chk({tag, "_rd1"}, fpu_rd1, a);
      chk({tag, "_rd2"}, fpu_rd2, b);
      chk({tag, "_funct5"}, 32'(fpu_funct5), 32'(f5));
      chk({tag, "_rm"}, 32'(fpu_rm), 32'(rm));
      cyc;
    end
    fpu_result = 32'h0BADF00D;
    #1;
    chk({tag, "_done_stall"}, 32'(fpu_stall), 32'd0);
    chk({tag, "_done_rv"}, 32'(result_valid), 32'd1);
    chk({tag, "_done_result"}, result, res);
  endtask
  initial begin
    rst = 1'b1;
    issue_e = 1'b0;
    flush_e = 1'b0;
    hold_m = 1'b0;
    funct5_e = 5'd0;
    rm_e = 3'd0;
    rs1_e = 32'd0;
    rs2_e = 32'd0;
    fpu_result = 32'd0;
    cyc;
    cyc;
    chk("rst_rd1", fpu_rd1, 32'd0);
    chk("rst_rd2", fpu_rd2, 32'd0);
    chk("rst_rm", 32'(fpu_rm), 32'd0);
    chk("rst_funct5", 32'(fpu_funct5), 32'd0);
    chk("rst_stall", 32'(fpu_stall), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    cyc;
    run_op("fadd", 5'b00000, 3'b010, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 1'b0);
    cyc;
    #1;
    chk("fadd_idle_rv", 32'(result_valid), 32'd0);
    chk("fadd_idle_result", result, 32'h40400000);
    chk("fadd_idle_rd1", fpu_rd1, 32'h3F800000);
    cyc;
    run_op("fdiv", 5'b00011, 3'b001, 32'h40400000, 32'h40C00000, 32'h3F000000, 10, 1'b0);
    cyc;
    issue_e = 1'b1;
    funct5_e = 5'b00000;
    rs1_e = 32'h40800000;
    rs2_e = 32'h3F800000;
    #1;
    chk("flush_issue_stall", 32'(fpu_stall), 32'd1);
    cyc;
    issue_e = 1'b0;
    fpu_result = 32'h40A00000;
    #1;
    chk("flush_busy_stall", 32'(fpu_stall), 32'd1);
    cyc;
    flush_e = 1'b1;
    #1;
    chk("flush_cycle_stall", 32'(fpu_stall), 32'd0);
    chk("flush_cycle_rv", 32'(result_valid), 32'd0);
    cyc;
    flush_e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("flush_after_stall", 32'(fpu_stall), 32'd0);
      chk("flush_after_rv", 32'(result_valid), 32'd0);
      chk("flush_after_result", result, 32'h3F000000);
      cyc;
    end
    issue_e = 1'b1;
    flush_e = 1'b1;
    #1;
    chk("issue_flush_stall", 32'(fpu_stall), 32'd0);
    cyc;
    issue_e = 1'b0;
    flush_e = 1'b0;
    #1;
    chk("issue_flush_next_stall", 32'(fpu_stall), 32'd0);
    chk("issue_flush_rd1", fpu_rd1, 32'h40800000);
    cyc;
    run_op("fmul", 5'b00010, 3'b000, 32'h40000000, 32'h40400000, 32'h40C00000, 2, 1'b0);
    hold_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      if (i == 2) hold_m = 1'b0;
      fpu_result = 32'h12345678;
      #1;
      chk("hold_rv", 32'(result_valid), 32'd1);
      chk("hold_stall", 32'(fpu_stall), 32'd0);
      chk("hold_result", result, 32'h40C00000);
    end
    cyc;
    #1;
    chk("hold_exit_rv", 32'(result_valid), 32'd0);
    chk("hold_exit_result", result, 32'h40C00000);
    cyc;
    issue_e = 1'b1;
    funct5_e = 5'b01011;
    rs1_e = 32'h41100000;
    rs2_e = 32'h0;
    #1;
    chk("fsqrt_issue_stall", 32'(fpu_stall), 32'd1);
    cyc;
    issue_e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fsqrt_busy_stall", 32'(fpu_stall), 32'd1);
      cyc;
    end
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    #1;
    chk("midrst_rd1", fpu_rd1, 32'd0);
    chk("midrst_funct5", 32'(fpu_funct5), 32'd0);
    chk("midrst_stall", 32'(fpu_stall), 32'd0);
    chk("midrst_rv", 32'(result_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    cyc;
    run_op("fsgnj", 5'b00100, 3'b000, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1, 1'b0);
    cyc;
    run_op("b2b_fmul", 5'b00010, 3'b000, 32'h40400000, 32'h40400000, 32'h41100000, 2, 1'b1);
    cyc;
    run_op("b2b_fcvt", 5'b11000, 3'b001, 32'h40E00000, 32'h0, 32'h00000007, 2, 1'b0);
    cyc;
    #1;
    chk("b2b_idle_rv", 32'(result_valid), 32'd0);
    chk("b2b_idle_stall", 32'(fpu_stall), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
